lcd_text_sequencer: RTL and testbench
=====================================

Name: lcd_text_sequencer

Overview:
- Command/text sequencer in front of lcd_controller. Runs the HD44780 power-on init list, then accepts characters from one requester over a valid/ready handshake.
- Converts each character into data writes, plus DDRAM address writes when the cursor moves to the other line, on the lcd_controller strobe/done interface.
- Tracks cursor position on a 2x16 display and services clear-screen requests, including the post-clear wait.

Parameters:
- CLK_PERIOD_NS, 20, clock period in ns, driven on ctrl_period_ns (8 bits).
- POWERUP_CYCLES, 750000, idle cycles after reset before the first init command (15 ms at 50 MHz).
- CLEAR_CYCLES, 82000, extra wait after the 0x01 clear command completes (1.64 ms at 50 MHz).
- CNT_W, 20, width of the shared delay counter; must hold max(POWERUP_CYCLES, CLEAR_CYCLES).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- char_valid  in  1  requester has a character.
- char_data  in  8  character code.
- char_ready  out  1  sequencer accepts char_data this cycle.
- clear_req  in  1  one-cycle pulse requesting a clear screen; latched internally.
- busy  out  1  high whenever state != IDLE or a clear is pending.
- init_done  out  1  goes high after the init list completes, stays high until reset.
- ctrl_rs  out  1  to lcd_controller rs_in (0 = command, 1 = data).
- ctrl_data  out  8  to lcd_controller data_in.
- ctrl_strobe  out  1  to lcd_controller strobe_in, one-cycle pulse.
- ctrl_period_ns  out  8  to lcd_controller period_clk_ns; constant CLK_PERIOD_NS.
- ctrl_done  in  1  from lcd_controller done.

Behaviour:
Reset (rst=0, asynchronous) takes effect immediately, including mid-transfer:
- Outputs: ctrl_strobe=0, ctrl_rs=0, ctrl_data=0x00, char_ready=0, busy=1, init_done=0.
- Internal: col=0, line=0, clear_pending=0, state=PWRUP, delay counter=0.

States:
- PWRUP: count POWERUP_CYCLES clocks, then go to INIT with init index 0.
- INIT: issue the init command at the current index, then go to WAIT. The list is 0x28, 0x06, 0x0C, 0x01.
- WAIT: wait for ctrl_done, then return to the calling flow. After the final init command (0x01), go to CLRDLY.
- CLRDLY: count CLEAR_CYCLES clocks. Then set col=0, line=0, clear_pending=0, init_done=1, and go to IDLE.
- IDLE:
  - char_ready=1 only when clear_pending=0.
  - If clear_pending=1: issue command 0x01, then WAIT, then CLRDLY.
  - Else if char_valid=1: capture char_data, then go to CHAR.
- CHAR: issue a data write (rs=1) of the captured byte, then WAIT, then POST.
- POST:
  - col<15: col+1, go to IDLE.
  - col==15: col=0, line toggles. Issue command 0xC0 (new line=1) or 0x80 (new line=0), then WAIT, then IDLE. Line 1 wraps to line 0.

"Issue":
- Drive ctrl_rs and ctrl_data, and pulse ctrl_strobe=1 for exactly one cycle.
- Hold ctrl_rs/ctrl_data stable until ctrl_done is seen.
- ctrl_done is ignored in the strobe cycle. WAIT exits on the first later cycle with ctrl_done=1.

Handshake and timing rules:
- Character accept latency: char_valid&&char_ready at edge N gives ctrl_strobe=1 at edge N+1.
- Only one outstanding controller transaction at a time.
- clear_req arriving in any state sets clear_pending, which is serviced at the next IDLE.
- A clear_req during PWRUP/INIT is absorbed by the init clear and discarded.
- Simultaneous clear_req and char_valid in IDLE: the clear wins, char_ready drops that cycle, and the character is not consumed.

Optional Feature:
LCD_SEQ_NEWLINE_EN:
- Defined: char_data 0x0A is consumed and not written as data. It behaves as a forced end-of-line: col=0, line toggles, and the 0xC0/0x80 address command is issued.
- Undefined: 0x0A is written to the display as an ordinary data byte.

Test Plan:
- Init (POWERUP_CYCLES=10, CLEAR_CYCLES=5): release rst. Expect strobes with rs=0 and data 0x28, 0x06, 0x0C, 0x01 in order, each after the previous ctrl_done. init_done=1 five cycles after the last done. No strobe before cycle 10.
- Char write: after init, char 0x41 with valid=1. Expect char_ready=1, then the next cycle strobe with rs=1, data=0x41. busy=1 until done, then char_ready=1 again.
- Line wrap: write 16 chars 0x30..0x3F. Expect after the 16th done a command 0xC0. Then 16 more chars, then a command 0x80. col and line return to 0.
- Clear priority: in IDLE, assert clear_req and char_valid (0x55) in the same cycle. Expect char_ready=0 and command 0x01, then 5 wait cycles, then 0x55 written at col 0 line 0.
- Reset mid-transfer: assert rst=0 one cycle after a data strobe, before done. Expect all outputs at reset values immediately, and the full init sequence replayed after release.
- LCD_SEQ_NEWLINE_EN: at col 3 line 0, send 0x0A. Defined: command 0xC0 and no data write. Undefined: data write 0x0A with rs=1.

Source files
------------

// File: rtl/lcd_text_sequencer_if.sv
// lcd_text_sequencer_if
//   Bus between lcd_text_sequencer and lcd_controller.
//   rs        : register select (0 = command, 1 = data)
//   data      : byte presented to the controller
//   strobe    : one-cycle start pulse
//   period_ns : clock period in ns, constant
//   done      : controller reports transfer complete
//   master = sequencer side, slave = controller side.
interface lcd_text_sequencer_if;
  logic       rs;
  logic [7:0] data;
  logic       strobe;
  logic [7:0] period_ns;
  logic       done;

  modport master (output rs, output data, output strobe, output period_ns, input done);
  modport slave  (input rs, input data, input strobe, input period_ns, output done);
endinterface

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
//   Runs the HD44780 power-on init list, then turns characters from a
//   valid/ready requester into controller data writes, inserting DDRAM
//   address commands when the cursor moves to the other line of a 2x16
//   display. Services clear-screen requests including the post-clear wait.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   char_valid  requester has a character
//   char_data   character code
//   char_ready  character accepted this cycle
//   clear_req   one-cycle clear-screen request, latched internally
//   busy        not idle, or a clear is pending
//   init_done   init list complete, held until reset
//   ctrl        controller bus (lcd_text_sequencer_if.master)
//
// Optional feature macro: LCD_SEQ_NEWLINE_EN
//   defined   : 0x0A is consumed as a forced end-of-line
//   undefined : 0x0A is written as ordinary data
module lcd_text_sequencer #(
  parameter int unsigned CLK_PERIOD_NS  = 20,
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned CLEAR_CYCLES   = 82000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic       init_done,
  lcd_text_sequencer_if.master ctrl
);

  typedef enum logic [2:0] {
    PWRUP, INIT, WAIT, CLRDLY, IDLE, CHAR, POST, CMD
  } state_t;

  // Where WAIT hands control back once the controller reports done.
  typedef enum logic [1:0] {
    RET_INIT, RET_CLEAR, RET_POST, RET_IDLE
  } ret_t;

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [1:0]       INIT_LAST  = 2'd3;

  state_t           state, state_d;
  ret_t             ret, ret_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       idx, idx_d;
  logic [3:0]       col, col_d;
  logic             line, line_d;
  logic             clear_pending, pend_d;
  logic             done_q, done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             strobe;
  logic             newline_hit;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

`ifdef LCD_SEQ_NEWLINE_EN
  assign newline_hit = (char_data == 8'h0A);
`else
  assign newline_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= PWRUP;
      ret           <= RET_INIT;
      cnt           <= '0;
      idx           <= '0;
      col           <= '0;
      line          <= 1'b0;
      clear_pending <= 1'b0;
      done_q        <= 1'b0;
      rs_q          <= 1'b0;
      data_q        <= '0;
    end else begin
      state         <= state_d;
      ret           <= ret_d;
      cnt           <= cnt_d;
      idx           <= idx_d;
      col           <= col_d;
      line          <= line_d;
      clear_pending <= pend_d;
      done_q        <= done_d;
      rs_q          <= rs_d;
      data_q        <= data_d;
    end
  end

  // rs/data are loaded on entry to an issuing state (INIT, CHAR, CMD) and
  // held untouched through WAIT, so the strobe is simply "in issuing state".
  always_comb begin
    state_d    = state;
    ret_d      = ret;
    cnt_d      = cnt;
    idx_d      = idx;
    col_d      = col;
    line_d     = line;
    pend_d     = clear_pending | clear_req;
    done_d     = done_q;
    rs_d       = rs_q;
    data_d     = data_q;
    strobe     = 1'b0;
    char_ready = 1'b0;

    case (state)
      PWRUP: begin
        if (cnt == PWRUP_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
          ret_d   = RET_INIT;
          state_d = INIT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      INIT, CHAR, CMD: begin
        strobe  = 1'b1;
        state_d = WAIT;
      end

      WAIT: begin
        if (ctrl.done) begin
          case (ret)
            RET_INIT: begin
              if (idx == INIT_LAST) begin
                cnt_d   = '0;
                state_d = CLRDLY;
              end else begin
                idx_d   = idx + 2'd1;
                data_d  = init_cmd(idx + 2'd1);
                state_d = INIT;
              end
            end
            RET_CLEAR: begin
              cnt_d   = '0;
              state_d = CLRDLY;
            end
            RET_POST: state_d = POST;
            default:  state_d = IDLE;
          endcase
        end
      end

      // Ending here also drops any clear that arrived during init or
      // during this clear: the screen has just been cleared anyway.
      CLRDLY: begin
        if (cnt == CLEAR_LAST) begin
          cnt_d   = '0;
          col_d   = '0;
          line_d  = 1'b0;
          pend_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      IDLE: begin
        // A same-cycle clear_req beats a waiting character.
        if (clear_pending || clear_req) begin
          rs_d    = 1'b0;
          data_d  = 8'h01;
          ret_d   = RET_CLEAR;
          state_d = CMD;
        end else begin
          char_ready = 1'b1;
          if (char_valid) begin
            if (newline_hit) begin
              col_d   = '0;
              line_d  = ~line;
              rs_d    = 1'b0;
              data_d  = line ? 8'h80 : 8'hC0;
              ret_d   = RET_IDLE;
              state_d = CMD;
            end else begin
              rs_d    = 1'b1;
              data_d  = char_data;
              ret_d   = RET_POST;
              state_d = CHAR;
            end
          end
        end
      end

      POST: begin
        if (col != 4'd15) begin
          col_d   = col + 4'd1;
          state_d = IDLE;
        end else begin
          col_d   = '0;
          line_d  = ~line;
          rs_d    = 1'b0;
          data_d  = line ? 8'h80 : 8'hC0;
          ret_d   = RET_IDLE;
          state_d = CMD;
        end
      end

      default: state_d = PWRUP;
    endcase
  end

  assign busy           = (state != IDLE) || clear_pending;
  assign init_done      = done_q;
  assign ctrl.rs        = rs_q;
  assign ctrl.data      = data_q;
  assign ctrl.strobe    = strobe;
  assign ctrl.period_ns = 8'(CLK_PERIOD_NS);

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// tb_lcd_text_sequencer
//   Directed bench for lcd_text_sequencer with short power-up/clear delays.
//   The bench plays the lcd_controller role by answering strobes with done.
module tb_lcd_text_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       clear_req = 1'b0;
  logic       busy;
  logic       init_done;

  int total = 0;
  int bad   = 0;

  lcd_text_sequencer_if bus ();

  lcd_text_sequencer #(
    .CLK_PERIOD_NS (20),
    .POWERUP_CYCLES(10),
    .CLEAR_CYCLES  (5),
    .CNT_W         (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .clear_req (clear_req),
    .busy      (busy),
    .init_done (init_done),
    .ctrl      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // All driving and sampling happens 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int limit, output logic got, output int waited);
    got = 1'b0;
    waited = 0;
    while (!got && waited <= limit) begin
      if (bus.strobe === 1'b1) got = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  task automatic finish_txn(input int lat);
    for (int k = 0; k < lat; k++) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] c, output logic got);
    int n;
    int w;
    n = 0;
    while (char_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    char_valid = 1'b1;
    char_data  = c;
    tick();
    char_valid = 1'b0;
    wait_strobe(3, got, w);
  endtask

  task automatic test_reset();
    bus.done = 1'b0;
    tick();
    tick();
    total++;
    if (bus.strobe !== 1'b0 || bus.rs !== 1'b0 || bus.data !== 8'h00 ||
        char_ready !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got strobe=%b rs=%b data=%h ready=%b busy=%b init_done=%b, want 0 0 00 0 1 0",
               bus.strobe, bus.rs, bus.data, char_ready, busy, init_done);
    end
    total++;
    if (bus.period_ns !== 8'd20) begin
      bad++;
      $display("FAIL period_ns: got %0d want 20", bus.period_ns);
    end
  endtask

  task automatic test_init(input bit clr_in_pwrup);
    logic [7:0] exp_cmd [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
    int         lat [4]     = '{1, 3, 2, 4};
    logic got;
    int   n;
    int   w;
    rst = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      if (bus.strobe === 1'b1) got = 1'b1;
      else begin
        if (clr_in_pwrup && n == 3) clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n++;
      end
    end
    total++;
    if (!got || n != 10) begin
      bad++;
      $display("FAIL init_first_strobe: got strobe=%b after %0d cycles, want strobe after 10", got, n);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_strobe(2, got, w);
      total++;
      if (!got || bus.rs !== 1'b0 || bus.data !== exp_cmd[i]) begin
        bad++;
        $display("FAIL init_cmd%0d: got strobe=%b rs=%b data=%h, want strobe=1 rs=0 data=%h",
                 i, got, bus.rs, bus.data, exp_cmd[i]);
      end
      finish_txn(lat[i]);
    end
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (init_done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL init_clrdly_hold: got init_done=%b busy=%b, want 0 1", init_done, busy);
    end
    tick();
    total++;
    if (init_done !== 1'b1 || busy !== 1'b0 || char_ready !== 1'b1) begin
      bad++;
      $display("FAIL init_done_edge: got init_done=%b busy=%b ready=%b, want 1 0 1",
               init_done, busy, char_ready);
    end
  endtask

  task automatic test_char();
    char_valid = 1'b1;
    char_data  = 8'h41;
    #1;
    total++;
    if (char_ready !== 1'b1) begin
      bad++;
      $display("FAIL char_ready_idle: got %b want 1", char_ready);
    end
    tick();
    char_valid = 1'b0;
    total++;
    if (bus.strobe !== 1'b1 || bus.rs !== 1'b1 || bus.data !== 8'h41 || char_ready !== 1'b0) begin
      bad++;
      $display("FAIL char_strobe: got strobe=%b rs=%b data=%h ready=%b, want 1 1 41 0",
               bus.strobe, bus.rs, bus.data, char_ready);
    end
    // done raised in the strobe cycle must not end the transfer
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    tick();
    total++;
    if (char_ready !== 1'b0 || busy !== 1'b1 || bus.strobe !== 1'b0 ||
        bus.rs !== 1'b1 || bus.data !== 8'h41) begin
      bad++;
      $display("FAIL char_wait_hold: got ready=%b busy=%b strobe=%b rs=%b data=%h, want 0 1 0 1 41",
               char_ready, busy, bus.strobe, bus.rs, bus.data);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total++;
    if (busy !== 1'b1 || char_ready !== 1'b0) begin
      bad++;
      $display("FAIL char_post: got busy=%b ready=%b, want 1 0", busy, char_ready);
    end
    tick();
    total++;
    if (busy !== 1'b0 || char_ready !== 1'b1) begin
      bad++;
      $display("FAIL char_back_idle: got busy=%b ready=%b, want 0 1", busy, char_ready);
    end
  endtask

  task automatic test_line_wrap();
    logic       got;
    int         w;
    logic [7:0] c;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_strobe(2, got, w);
    total++;
    if (!got || bus.rs !== 1'b0 || bus.data !== 8'h01) begin
      bad++;
      $display("FAIL wrap_clear: got strobe=%b rs=%b data=%h, want 1 0 01", got, bus.rs, bus.data);
    end
    finish_txn(2);
    for (int i = 0; i < 32; i++) begin
      c = 8'h30 + 8'(i % 16);
      push_char(c, got);
      total++;
      if (!got || bus.rs !== 1'b1 || bus.data !== c) begin
        bad++;
        $display("FAIL wrap_char%0d: got strobe=%b rs=%b data=%h, want 1 1 %h", i, got, bus.rs, bus.data, c);
      end
      finish_txn(1 + (i % 3));
      if (i == 14) begin
        wait_strobe(3, got, w);
        total++;
        if (got !== 1'b0) begin
          bad++;
          $display("FAIL wrap_early_addr: got strobe=%b after col 14, want 0", got);
        end
      end
      if (i == 15 || i == 31) begin
        wait_strobe(3, got, w);
        total++;
        if (!got || bus.rs !== 1'b0 || bus.data !== ((i == 15) ? 8'hC0 : 8'h80)) begin
          bad++;
          $display("FAIL wrap_addr%0d: got strobe=%b rs=%b data=%h, want 1 0 %h",
                   i, got, bus.rs, bus.data, (i == 15) ? 8'hC0 : 8'h80);
        end
        finish_txn(2);
      end
    end
  endtask

  task automatic test_clear_priority();
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h55;
    #1;
    total++;
    if (char_ready !== 1'b0) begin
      bad++;
      $display("FAIL clrpri_ready: got %b want 0", char_ready);
    end
    tick();
    clear_req = 1'b0;
    total++;
    if (bus.strobe !== 1'b1 || bus.rs !== 1'b0 || bus.data !== 8'h01 || char_ready !== 1'b0) begin
      bad++;
      $display("FAIL clrpri_cmd: got strobe=%b rs=%b data=%h ready=%b, want 1 0 01 0",
               bus.strobe, bus.rs, bus.data, char_ready);
    end
    finish_txn(2);
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (char_ready !== 1'b0 || busy !== 1'b1 || bus.strobe !== 1'b0) begin
      bad++;
      $display("FAIL clrpri_delay: got ready=%b busy=%b strobe=%b, want 0 1 0", char_ready, busy, bus.strobe);
    end
    tick();
    total++;
    if (char_ready !== 1'b1) begin
      bad++;
      $display("FAIL clrpri_idle: got ready=%b want 1", char_ready);
    end
    tick();
    char_valid = 1'b0;
    total++;
    if (bus.strobe !== 1'b1 || bus.rs !== 1'b1 || bus.data !== 8'h55) begin
      bad++;
      $display("FAIL clrpri_char: got strobe=%b rs=%b data=%h, want 1 1 55", bus.strobe, bus.rs, bus.data);
    end
    finish_txn(1);
  endtask

  task automatic test_newline();
    logic got;
    int   w;
    push_char(8'h61, got);
    total++;
    if (!got || bus.rs !== 1'b1 || bus.data !== 8'h61) begin
      bad++;
      $display("FAIL nl_pre1: got strobe=%b rs=%b data=%h, want 1 1 61", got, bus.rs, bus.data);
    end
    finish_txn(1);
    push_char(8'h62, got);
    total++;
    if (!got || bus.rs !== 1'b1 || bus.data !== 8'h62) begin
      bad++;
      $display("FAIL nl_pre2: got strobe=%b rs=%b data=%h, want 1 1 62", got, bus.rs, bus.data);
    end
    finish_txn(1);
    push_char(8'h0A, got);
`ifdef LCD_SEQ_NEWLINE_EN
    total++;
    if (!got || bus.rs !== 1'b0 || bus.data !== 8'hC0) begin
      bad++;
      $display("FAIL nl_addr: got strobe=%b rs=%b data=%h, want 1 0 C0", got, bus.rs, bus.data);
    end
`else
    total++;
    if (!got || bus.rs !== 1'b1 || bus.data !== 8'h0A) begin
      bad++;
      $display("FAIL nl_data: got strobe=%b rs=%b data=%h, want 1 1 0A", got, bus.rs, bus.data);
    end
`endif
    finish_txn(1);
    wait_strobe(3, got, w);
    total++;
    if (got !== 1'b0 || char_ready !== 1'b1) begin
      bad++;
      $display("FAIL nl_no_extra: got strobe=%b ready=%b, want 0 1", got, char_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    push_char(8'h77, got);
    total++;
    if (!got || bus.rs !== 1'b1 || bus.data !== 8'h77) begin
      bad++;
      $display("FAIL rstmid_char: got strobe=%b rs=%b data=%h, want 1 1 77", got, bus.rs, bus.data);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (bus.strobe !== 1'b0 || bus.rs !== 1'b0 || bus.data !== 8'h00 ||
        char_ready !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: got strobe=%b rs=%b data=%h ready=%b busy=%b init_done=%b, want 0 0 00 0 1 0",
               bus.strobe, bus.rs, bus.data, char_ready, busy, init_done);
    end
    tick();
    tick();
    test_init(1'b1);
  endtask

  initial begin
    test_reset();
    test_init(1'b0);
    test_char();
    test_line_wrap();
    test_clear_priority();
    test_newline();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
